// File: rtl/i2c_pkg.sv
// Shared types for the I2C transaction arbiter: FSM states, response status codes
// and the device address width.
package i2c_pkg;

    localparam int ADDR_W = 7;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_ARB,
        ST_CMD_REG,
        ST_DAT_REG,
        ST_CMD_WR,
        ST_DAT_WR,
        ST_CMD_RD,
        ST_WAIT_RD,
        ST_WAIT_DONE,
        ST_RESP
    } state_t;

    typedef enum logic [1:0] {
        STATUS_OK      = 2'd0,
        STATUS_NACK    = 2'd1,
        STATUS_TIMEOUT = 2'd2
    } status_t;

endpackage

// File: rtl/i2c_rr_arbiter.sv
// Round-robin grant over N_REQ requesters. The search starts at the pointer and wraps;
// the pointer moves one past the winner whenever a grant is taken.
module i2c_rr_arbiter #(
    parameter int N_REQ = 2
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic [N_REQ-1:0]         i_req,
    input  logic                     i_advance,
    output logic                     o_any,
    output logic [$clog2(N_REQ)-1:0] o_gnt_idx
);

    localparam int IW = $clog2(N_REQ);

    logic [IW-1:0] r_ptr;
    int            w_idx;

    // Walk offsets from farthest to nearest so the nearest requester wins.
    always_comb begin
        o_any     = 1'b0;
        o_gnt_idx = '0;
        w_idx     = 0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            w_idx = int'(r_ptr) + i;
            if (w_idx >= N_REQ) begin
                w_idx = w_idx - N_REQ;
            end
            if (i_req[w_idx]) begin
                o_any     = 1'b1;
                o_gnt_idx = IW'(w_idx);
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_ptr <= '0;
        end else if (i_advance && o_any) begin
            r_ptr <= (int'(o_gnt_idx) == N_REQ - 1) ? '0 : o_gnt_idx + 1'b1;
        end
    end

endmodule

// File: rtl/i2c_txn_arbiter.sv
// Shares one I2C master between N_REQ requesters: grants round-robin, expands each
// single-byte register access into master command/data streams and returns one response.
module i2c_txn_arbiter import i2c_pkg::*; #(
    parameter int          N_REQ          = 2,
    parameter int unsigned TIMEOUT_CYCLES = 65535
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic [N_REQ-1:0]      req_valid_i,
    output logic [N_REQ-1:0]      req_ready_o,
    input  logic [N_REQ-1:0]      req_write_i,
    input  logic [7*N_REQ-1:0]    req_dev_i,
    input  logic [8*N_REQ-1:0]    req_reg_i,
    input  logic [8*N_REQ-1:0]    req_wdata_i,
    output logic [N_REQ-1:0]      rsp_valid_o,
    output logic [7:0]            rsp_rdata_o,
    output logic [1:0]            rsp_status_o,
    output logic [ADDR_W-1:0]     m_cmd_addr_o,
    output logic                  m_cmd_start_o,
    output logic                  m_cmd_read_o,
    output logic                  m_cmd_write_o,
    output logic                  m_cmd_stop_o,
    output logic                  m_cmd_valid_o,
    input  logic                  m_cmd_ready_i,
    output logic [7:0]            m_wr_data_o,
    output logic                  m_wr_valid_o,
    output logic                  m_wr_last_o,
    input  logic                  m_wr_ready_i,
    input  logic [7:0]            m_rd_data_i,
    input  logic                  m_rd_valid_i,
    output logic                  m_rd_ready_o,
    input  logic                  m_busy_i,
    input  logic                  m_nack_i
);

    localparam int IW = $clog2(N_REQ);

    state_t            r_state;
    logic [IW-1:0]     r_gnt;
    logic              r_write;
    logic [7:0]        r_reg;
    logic [7:0]        r_wdata;
    logic [7:0]        r_rdata;
    logic              r_nack;
    logic [31:0]       r_tmo_cnt;

    logic              w_any;
    logic [IW-1:0]     w_gnt_idx;
    logic              w_timeout;
    logic              w_nack_any;

    i2c_rr_arbiter #(.N_REQ(N_REQ)) u_rr (
        .i_clk     (clk_i),
        .i_rst_n   (rst_ni),
        .i_req     (req_valid_i),
        .i_advance (r_state == ST_ARB),
        .o_any     (w_any),
        .o_gnt_idx (w_gnt_idx)
    );

    // Only states that wait on the master can expire; the counter restarts on every state change.
    assign w_timeout = (TIMEOUT_CYCLES != 0) &&
                       (r_state inside {ST_CMD_REG, ST_DAT_REG, ST_CMD_WR, ST_DAT_WR,
                                        ST_CMD_RD, ST_WAIT_RD, ST_WAIT_DONE}) &&
                       (r_tmo_cnt == 32'(TIMEOUT_CYCLES - 1));
    assign w_nack_any = r_nack || m_nack_i;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_state       <= ST_IDLE;
            r_gnt         <= '0;
            r_write       <= 1'b0;
            r_reg         <= '0;
            r_wdata       <= '0;
            r_rdata       <= '0;
            r_nack        <= 1'b0;
            r_tmo_cnt     <= '0;
            req_ready_o   <= '0;
            rsp_valid_o   <= '0;
            rsp_rdata_o   <= '0;
            rsp_status_o  <= '0;
            m_cmd_addr_o  <= '0;
            m_cmd_start_o <= 1'b0;
            m_cmd_read_o  <= 1'b0;
            m_cmd_write_o <= 1'b0;
            m_cmd_stop_o  <= 1'b0;
            m_cmd_valid_o <= 1'b0;
            m_wr_data_o   <= '0;
            m_wr_valid_o  <= 1'b0;
            m_wr_last_o   <= 1'b0;
            m_rd_ready_o  <= 1'b0;
        end else begin
            req_ready_o <= '0;
            rsp_valid_o <= '0;
            r_tmo_cnt   <= r_tmo_cnt + 32'd1;
            if (m_nack_i && (r_state inside {ST_CMD_REG, ST_DAT_REG, ST_CMD_WR, ST_DAT_WR,
                                              ST_CMD_RD, ST_WAIT_RD, ST_WAIT_DONE})) begin
                r_nack <= 1'b1;
            end

            case (r_state)
                ST_IDLE: begin
                    r_tmo_cnt <= '0;
                    if (w_any) begin
                        r_state <= ST_ARB;
                    end
                end
                ST_ARB: begin
                    r_tmo_cnt <= '0;
                    if (w_any) begin
                        r_gnt                  <= w_gnt_idx;
                        req_ready_o[w_gnt_idx] <= 1'b1;
                        r_write                <= req_write_i[w_gnt_idx];
                        r_reg                  <= req_reg_i[int'(w_gnt_idx)*8 +: 8];
                        r_wdata                <= req_wdata_i[int'(w_gnt_idx)*8 +: 8];
                        r_rdata                <= '0;
                        r_nack                 <= 1'b0;
                        m_cmd_addr_o           <= req_dev_i[int'(w_gnt_idx)*ADDR_W +: ADDR_W];
                        m_cmd_start_o          <= 1'b1;
                        m_cmd_read_o           <= 1'b0;
                        m_cmd_write_o          <= 1'b1;
                        m_cmd_stop_o           <= 1'b0;
                        m_cmd_valid_o          <= 1'b1;
                        r_state                <= ST_CMD_REG;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_CMD_REG: begin
                    if (m_cmd_ready_i) begin
                        r_tmo_cnt     <= '0;
                        m_cmd_valid_o <= 1'b0;
                        m_wr_data_o   <= r_reg;
                        m_wr_last_o   <= 1'b1;
                        m_wr_valid_o  <= 1'b1;
                        r_state       <= ST_DAT_REG;
                    end
                end
                ST_DAT_REG: begin
                    if (m_wr_ready_i) begin
                        r_tmo_cnt     <= '0;
                        m_wr_valid_o  <= 1'b0;
                        m_cmd_start_o <= !r_write;
                        m_cmd_read_o  <= !r_write;
                        m_cmd_write_o <= r_write;
                        m_cmd_stop_o  <= 1'b1;
                        m_cmd_valid_o <= 1'b1;
                        r_state       <= r_write ? ST_CMD_WR : ST_CMD_RD;
                    end
                end
                ST_CMD_WR: begin
                    if (m_cmd_ready_i) begin
                        r_tmo_cnt     <= '0;
                        m_cmd_valid_o <= 1'b0;
                        m_wr_data_o   <= r_wdata;
                        m_wr_last_o   <= 1'b1;
                        m_wr_valid_o  <= 1'b1;
                        r_state       <= ST_DAT_WR;
                    end
                end
                ST_DAT_WR: begin
                    if (m_wr_ready_i) begin
                        r_tmo_cnt    <= '0;
                        m_wr_valid_o <= 1'b0;
                        r_state      <= ST_WAIT_DONE;
                    end
                end
                ST_CMD_RD: begin
                    if (m_cmd_ready_i) begin
                        r_tmo_cnt     <= '0;
                        m_cmd_valid_o <= 1'b0;
                        m_rd_ready_o  <= 1'b1;
                        r_state       <= ST_WAIT_RD;
                    end
                end
                ST_WAIT_RD: begin
                    if (m_rd_valid_i) begin
                        r_tmo_cnt    <= '0;
                        r_rdata      <= m_rd_data_i;
                        m_rd_ready_o <= 1'b0;
                        r_state      <= ST_WAIT_DONE;
                    end
                end
                ST_WAIT_DONE: begin
                    if (!m_busy_i) begin
                        r_tmo_cnt          <= '0;
                        rsp_valid_o[r_gnt] <= 1'b1;
                        rsp_status_o       <= w_nack_any ? STATUS_NACK : STATUS_OK;
                        rsp_rdata_o        <= w_nack_any ? 8'h00 : r_rdata;
                        r_state            <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    r_tmo_cnt <= '0;
                    r_state   <= ST_IDLE;
                end
                default: begin
                    r_tmo_cnt <= '0;
                    r_state   <= ST_IDLE;
                end
            endcase

            // Abort overrides whatever the state decided this cycle, including a pending NACK.
            if (w_timeout) begin
                r_tmo_cnt          <= '0;
                m_cmd_valid_o      <= 1'b0;
                m_wr_valid_o       <= 1'b0;
                m_rd_ready_o       <= 1'b0;
                rsp_valid_o[r_gnt] <= 1'b1;
                rsp_status_o       <= STATUS_TIMEOUT;
                rsp_rdata_o        <= 8'h00;
                r_state            <= ST_RESP;
            end
        end
    end

endmodule

// File: tb/tb_i2c_txn_arbiter.sv
// Directed bench for i2c_txn_arbiter: small reactive master model, stream monitors and
// immediate-assertion checks against hand-computed expectations.
module tb_i2c_txn_arbiter;

    logic        clk = 1'b0;
    logic        rst_ni;
    logic [1:0]  req_valid_i, req_ready_o, req_write_i, rsp_valid_o;
    logic [13:0] req_dev_i;
    logic [15:0] req_reg_i, req_wdata_i;
    logic [7:0]  rsp_rdata_o, m_wr_data_o, m_rd_data_i;
    logic [1:0]  rsp_status_o;
    logic [6:0]  m_cmd_addr_o;
    logic        m_cmd_start_o, m_cmd_read_o, m_cmd_write_o, m_cmd_stop_o, m_cmd_valid_o;
    logic        m_cmd_ready_i, m_wr_valid_o, m_wr_last_o, m_wr_ready_i;
    logic        m_rd_valid_i, m_rd_ready_o, m_busy_i, m_nack_i;

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          reqLeft[2];
    int          busyCnt;
    int          rdCyc;
    bit          rdEnable;
    bit          nackArm;
    bit          found;
    logic [7:0]  rdByte;

    logic [10:0] cmdLog[$];
    logic [8:0]  byteLog[$];
    int          gntLog[$];
    logic [1:0]  rspIdx[$];
    logic [1:0]  rspStat[$];
    logic [7:0]  rspData[$];
    int          rspCyc[$];

    i2c_txn_arbiter #(.N_REQ(2), .TIMEOUT_CYCLES(16)) dut (
        .clk_i(clk), .rst_ni(rst_ni),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_write_i(req_write_i),
        .req_dev_i(req_dev_i), .req_reg_i(req_reg_i), .req_wdata_i(req_wdata_i),
        .rsp_valid_o(rsp_valid_o), .rsp_rdata_o(rsp_rdata_o), .rsp_status_o(rsp_status_o),
        .m_cmd_addr_o(m_cmd_addr_o), .m_cmd_start_o(m_cmd_start_o), .m_cmd_read_o(m_cmd_read_o),
        .m_cmd_write_o(m_cmd_write_o), .m_cmd_stop_o(m_cmd_stop_o), .m_cmd_valid_o(m_cmd_valid_o),
        .m_cmd_ready_i(m_cmd_ready_i), .m_wr_data_o(m_wr_data_o), .m_wr_valid_o(m_wr_valid_o),
        .m_wr_last_o(m_wr_last_o), .m_wr_ready_i(m_wr_ready_i), .m_rd_data_i(m_rd_data_i),
        .m_rd_valid_i(m_rd_valid_i), .m_rd_ready_o(m_rd_ready_o), .m_busy_i(m_busy_i),
        .m_nack_i(m_nack_i)
    );

    always #5 clk = ~clk;

    // Stream handshakes complete on the rising edge; log them there as {addr,start,read,write,stop}.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst_ni && m_cmd_valid_o && m_cmd_ready_i)
            cmdLog.push_back({m_cmd_addr_o, m_cmd_start_o, m_cmd_read_o, m_cmd_write_o, m_cmd_stop_o});
        if (rst_ni && m_wr_valid_o && m_wr_ready_i)
            byteLog.push_back({m_wr_data_o, m_wr_last_o});
    end

    always @(negedge clk) begin
        if (rst_ni) begin
            if (req_ready_o[0]) gntLog.push_back(0);
            if (req_ready_o[1]) gntLog.push_back(1);
            if (|rsp_valid_o) begin
                rspIdx.push_back(rsp_valid_o);
                rspStat.push_back(rsp_status_o);
                rspData.push_back(rsp_rdata_o);
                rspCyc.push_back(cyc);
            end
        end
    end

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input int idx, input bit wr, input logic [6:0] dev,
                                 input logic [7:0] regAddr, input logic [7:0] wdata);
        req_write_i[idx]         = wr;
        req_dev_i[idx*7 +: 7]    = dev;
        req_reg_i[idx*8 +: 8]    = regAddr;
        req_wdata_i[idx*8 +: 8]  = wdata;
        req_valid_i[idx]         = 1'b1;
        reqLeft[idx]             = 1;
    endtask

    task automatic clearLogs();
        cmdLog.delete(); byteLog.delete(); gntLog.delete();
        rspIdx.delete(); rspStat.delete(); rspData.delete(); rspCyc.delete();
    endtask

    // Per-cycle requester and master model, run on the falling edge.
    task automatic driveStep();
        for (int i = 0; i < 2; i++) begin
            if (req_ready_o[i] && req_valid_i[i]) begin
                reqLeft[i]--;
                if (reqLeft[i] <= 0) req_valid_i[i] = 1'b0;
            end
        end
        m_rd_valid_i = rdEnable && m_rd_ready_o;
        m_rd_data_i  = rdByte;
        if (nackArm && m_wr_valid_o) begin
            m_nack_i = 1'b1;
            nackArm  = 1'b0;
        end else begin
            m_nack_i = 1'b0;
        end
        if ((m_cmd_valid_o && m_cmd_ready_i) || (m_wr_valid_o && m_wr_ready_i) || m_rd_ready_o)
            busyCnt = 3;
        else if (busyCnt > 0)
            busyCnt--;
        m_busy_i = (busyCnt > 0);
        if (m_rd_ready_o && rdCyc < 0) rdCyc = cyc;
    endtask

    task automatic waitRsp(input int n, input int budget);
        for (int k = 0; k < budget && rspIdx.size() < n; k++) begin
            @(negedge clk);
            driveStep();
        end
        checkOutput("rsp_count", 64'(rspIdx.size()), 64'(n));
    endtask

    function automatic logic [63:0] allOutputs();
        return 64'({req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_status_o, m_cmd_addr_o,
                    m_cmd_start_o, m_cmd_read_o, m_cmd_write_o, m_cmd_stop_o, m_cmd_valid_o,
                    m_wr_data_o, m_wr_valid_o, m_wr_last_o, m_rd_ready_o});
    endfunction

    initial begin
        rst_ni = 1'b0; req_valid_i = '0; req_write_i = '0; req_dev_i = '0;
        req_reg_i = '0; req_wdata_i = '0; m_cmd_ready_i = 1'b1; m_wr_ready_i = 1'b1;
        m_rd_data_i = '0; m_rd_valid_i = 1'b0; m_busy_i = 1'b0; m_nack_i = 1'b0;
        reqLeft[0] = 0; reqLeft[1] = 0; busyCnt = 0; rdCyc = -1;
        rdEnable = 1'b0; nackArm = 1'b0; rdByte = '0;
        repeat (3) @(negedge clk);
        checkOutput("reset_outputs", allOutputs(), 64'd0);
        rst_ni = 1'b1;

        // Write: requester 0, dev 0x50, reg 0x12, data 0xA5.
        clearLogs();
        applyStimulus(0, 1'b1, 7'h50, 8'h12, 8'hA5);
        waitRsp(1, 80);
        checkOutput("wr_cmd_count", 64'(cmdLog.size()), 64'd2);
        checkOutput("wr_cmd0", 64'(cmdLog[0]), 64'({7'h50, 4'b1010}));
        checkOutput("wr_cmd1", 64'(cmdLog[1]), 64'({7'h50, 4'b0011}));
        checkOutput("wr_byte_count", 64'(byteLog.size()), 64'd2);
        checkOutput("wr_byte0", 64'(byteLog[0]), 64'({8'h12, 1'b1}));
        checkOutput("wr_byte1", 64'(byteLog[1]), 64'({8'hA5, 1'b1}));
        checkOutput("wr_rsp_idx", 64'(rspIdx[0]), 64'(2'b01));
        checkOutput("wr_rsp_status", 64'(rspStat[0]), 64'd0);
        checkOutput("wr_rsp_rdata", 64'(rspData[0]), 64'd0);

        // Read: requester 1, dev 0x50, reg 0x34, master returns 0x5C.
        clearLogs();
        rdEnable = 1'b1; rdByte = 8'h5C;
        applyStimulus(1, 1'b0, 7'h50, 8'h34, 8'h00);
        waitRsp(1, 80);
        checkOutput("rd_cmd_count", 64'(cmdLog.size()), 64'd2);
        checkOutput("rd_cmd0", 64'(cmdLog[0]), 64'({7'h50, 4'b1010}));
        checkOutput("rd_cmd1", 64'(cmdLog[1]), 64'({7'h50, 4'b1101}));
        checkOutput("rd_byte_count", 64'(byteLog.size()), 64'd1);
        checkOutput("rd_byte0", 64'(byteLog[0]), 64'({8'h34, 1'b1}));
        checkOutput("rd_rsp_idx", 64'(rspIdx[0]), 64'(2'b10));
        checkOutput("rd_rsp_status", 64'(rspStat[0]), 64'd0);
        checkOutput("rd_rsp_rdata", 64'(rspData[0]), 64'h5C);
        checkOutput("rd_ready_low", 64'(m_rd_ready_o), 64'd0);

        // NACK after the address phase of a write; the sequence still completes.
        clearLogs();
        nackArm = 1'b1;
        applyStimulus(0, 1'b1, 7'h2A, 8'h01, 8'h77);
        waitRsp(1, 80);
        checkOutput("nack_cmd_count", 64'(cmdLog.size()), 64'd2);
        checkOutput("nack_byte1", 64'(byteLog[1]), 64'({8'h77, 1'b1}));
        checkOutput("nack_rsp_idx", 64'(rspIdx[0]), 64'(2'b01));
        checkOutput("nack_rsp_status", 64'(rspStat[0]), 64'd1);
        checkOutput("nack_rsp_rdata", 64'(rspData[0]), 64'd0);

        clearLogs();
        rdByte = 8'h3C;
        applyStimulus(1, 1'b0, 7'h2A, 8'h02, 8'h00);
        waitRsp(1, 80);
        checkOutput("after_nack_status", 64'(rspStat[0]), 64'd0);
        checkOutput("after_nack_rdata", 64'(rspData[0]), 64'h3C);
        repeat (3) @(negedge clk);
        checkOutput("rdata_held", 64'(rsp_rdata_o), 64'h3C);

        // Read whose data never arrives: aborts 16 cycles after entering WAIT_RD.
        clearLogs();
        rdEnable = 1'b0; rdCyc = -1;
        applyStimulus(1, 1'b0, 7'h50, 8'h40, 8'h00);
        waitRsp(1, 80);
        checkOutput("tmo_rsp_idx", 64'(rspIdx[0]), 64'(2'b10));
        checkOutput("tmo_rsp_status", 64'(rspStat[0]), 64'd2);
        checkOutput("tmo_rsp_rdata", 64'(rspData[0]), 64'd0);
        checkOutput("tmo_latency", 64'(rspCyc[0] - rdCyc), 64'd16);
        checkOutput("tmo_rd_ready_low", 64'(m_rd_ready_o), 64'd0);

        // Reset while the write-data byte is on the stream.
        clearLogs();
        applyStimulus(0, 1'b1, 7'h50, 8'h12, 8'hA5);
        found = 1'b0;
        for (int k = 0; k < 60 && !found; k++) begin
            @(negedge clk);
            driveStep();
            if (m_wr_valid_o && m_wr_data_o == 8'hA5) found = 1'b1;
        end
        checkOutput("reach_dat_wr", 64'(found), 64'd1);
        rst_ni = 1'b0;
        @(negedge clk);
        checkOutput("midreset_outputs", allOutputs(), 64'd0);
        @(negedge clk);
        rst_ni = 1'b1;
        checkOutput("midreset_no_rsp", 64'(rspIdx.size()), 64'd0);
        clearLogs();
        busyCnt = 0; m_busy_i = 1'b0; m_nack_i = 1'b0;
        applyStimulus(0, 1'b1, 7'h50, 8'h12, 8'hA5);
        waitRsp(1, 80);
        checkOutput("postreset_cmd_count", 64'(cmdLog.size()), 64'd2);
        checkOutput("postreset_byte1", 64'(byteLog[1]), 64'({8'hA5, 1'b1}));
        checkOutput("postreset_status", 64'(rspStat[0]), 64'd0);

        // Both requesters valid out of reset, four writes each: grants must alternate.
        rst_ni = 1'b0;
        applyStimulus(0, 1'b1, 7'h11, 8'h01, 8'hB0);
        applyStimulus(1, 1'b1, 7'h22, 8'h02, 8'hB1);
        reqLeft[0] = 4; reqLeft[1] = 4;
        repeat (2) @(negedge clk);
        clearLogs();
        rst_ni = 1'b1;
        waitRsp(8, 600);
        checkOutput("b2b_grant_count", 64'(gntLog.size()), 64'd8);
        for (int i = 0; i < 8; i++) begin
            checkOutput($sformatf("b2b_grant%0d", i), 64'(gntLog[i]), 64'(i % 2));
            checkOutput($sformatf("b2b_rsp_idx%0d", i), 64'(rspIdx[i]), (i % 2 == 1) ? 64'd2 : 64'd1);
            checkOutput($sformatf("b2b_status%0d", i), 64'(rspStat[i]), 64'd0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
